// File: rtl/video_pkg.sv
// Shared video-path types: colour standard selection and fixed-point RGB->YCbCr coefficients.
package video_pkg;

    typedef enum logic [1:0] {
        MODE_601  = 2'd0,
        MODE_709  = 2'd1,
        MODE_GREY = 2'd2
    } mode_e;

    localparam int unsigned RGB2YCC_LAT = 4;
    localparam int unsigned COEF_W      = 16;

    typedef logic signed [COEF_W-1:0] coef_t;

    // Index 0/1/2 of each row weights red/green/blue.
    typedef struct packed {
        coef_t [2:0] y;
        coef_t [2:0] cb;
        coef_t [2:0] cr;
    } coef_set_t;

    // Table values are in units of 2^-10; rescale (round half up) to the requested precision.
    function automatic coef_t scale_coef(int c, int unsigned frac);
        int s;
        if (frac >= 10) begin
            s = c * (1 << (frac - 10));
        end else begin
            s = (c * (1 << frac) + 512) >>> 10;
        end
        return coef_t'(s);
    endfunction

    function automatic coef_set_t get_coefs(mode_e mode, int unsigned frac = 10);
        int c [9];
        coef_set_t cs;
        case (mode)
            MODE_709:  c = '{218, 732, 74, -117, -395, 512, 512, -465, -47};
            MODE_GREY: c = '{341, 342, 341, 0, 0, 0, 0, 0, 0};
            default:   c = '{306, 601, 117, -173, -339, 512, 512, -429, -83};
        endcase
        for (int i = 0; i < 3; i++) begin
            cs.y[i]  = scale_coef(c[i], frac);
            cs.cb[i] = scale_coef(c[i + 3], frac);
            cs.cr[i] = scale_coef(c[i + 6], frac);
        end
        return cs;
    endfunction

endpackage

// File: rtl/sync_delay.sv
// N-stage shift register with async reset, used to align sync strobes with pipelined data.
module sync_delay #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/rgb2ycbcr_pipe.sv
// Four-stage RGB to full-range YCbCr converter with frame-locked standard selection
// and output-side pixel/line position tracking.
module rgb2ycbcr_pipe
    import video_pkg::*;
#(
    parameter int unsigned COLORDEPTH = 8,
    parameter int unsigned COEF_FRAC  = 10,
    parameter int unsigned MAX_W      = 2048,
    parameter int unsigned MAX_H      = 2048,
    parameter logic [1:0]  MODE_RST   = 2'd0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [COLORDEPTH-1:0]      red_i,
    input  logic [COLORDEPTH-1:0]      green_i,
    input  logic [COLORDEPTH-1:0]      blue_i,
    input  logic                       dv_i,
    input  logic                       hs_i,
    input  logic                       vs_i,
    input  logic [1:0]                 mode_i,
    output logic [COLORDEPTH-1:0]      y_o,
    output logic [COLORDEPTH-1:0]      cb_o,
    output logic [COLORDEPTH-1:0]      cr_o,
    output logic                       dv_o,
    output logic                       hs_o,
    output logic                       vs_o,
    output logic                       line_end_o,
    output logic                       frame_start_o,
    output logic [$clog2(MAX_W)-1:0]   x_o,
    output logic [$clog2(MAX_H)-1:0]   line_o,
    output logic [1:0]                 mode_o
);

    localparam int unsigned AW = COLORDEPTH + COEF_FRAC + 3;
    localparam int unsigned XW = $clog2(MAX_W);
    localparam int unsigned YW = $clog2(MAX_H);

    typedef logic signed [AW-1:0] acc_t;

    localparam acc_t                  RND     = acc_t'(1) << (COEF_FRAC - 1);
    localparam acc_t                  MID     = acc_t'(1) << (COLORDEPTH - 1 + COEF_FRAC);
    localparam logic [COLORDEPTH-1:0] PIX_MAX = '1;
    localparam logic [XW-1:0]         X_LAST  = XW'(MAX_W - 1);
    localparam logic [YW-1:0]         Y_LAST  = YW'(MAX_H - 1);

    function automatic acc_t mul(coef_t c, logic [COLORDEPTH-1:0] p);
        return acc_t'(c) * acc_t'({1'b0, p});
    endfunction

    function automatic logic [COLORDEPTH-1:0] sat(acc_t acc);
        acc_t s;
        s = acc >>> COEF_FRAC;
        if (s < 0) return '0;
        if (s > acc_t'(PIX_MAX)) return PIX_MAX;
        return s[COLORDEPTH-1:0];
    endfunction

    // Stage 1: input register and mode latch.
    logic [COLORDEPTH-1:0] rgb_s1_q [3];
    logic [1:0]            pend_q, act_q, mode_eff;
    logic                  vs_s1_q, vs_s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_s1_q <= '{default: '0};
            pend_q   <= MODE_RST;
            act_q    <= MODE_RST;
            vs_s1_q  <= 1'b0;
            vs_s2_q  <= 1'b0;
        end else begin
            rgb_s1_q <= '{red_i, green_i, blue_i};
            pend_q   <= mode_i;
            act_q    <= mode_eff;
            vs_s1_q  <= vs_i;
            vs_s2_q  <= vs_s1_q;
        end
    end

    // The pixel carrying the vsync rise already uses the mode requested alongside it.
    assign mode_eff = (vs_s1_q && !vs_s2_q) ? pend_q : act_q;

    // Stage 2: products.
    coef_set_t coefs;
    acc_t      prod_y_q [3];
    acc_t      prod_cb_q [3];
    acc_t      prod_cr_q [3];
    logic [1:0] mode_s2_q, mode_s3_q;

    always_comb coefs = get_coefs(mode_e'(mode_eff), COEF_FRAC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                prod_y_q[i]  <= '0;
                prod_cb_q[i] <= '0;
                prod_cr_q[i] <= '0;
            end
            mode_s2_q <= MODE_RST;
        end else begin
            for (int i = 0; i < 3; i++) begin
                prod_y_q[i]  <= mul(coefs.y[i], rgb_s1_q[i]);
                prod_cb_q[i] <= mul(coefs.cb[i], rgb_s1_q[i]);
                prod_cr_q[i] <= mul(coefs.cr[i], rgb_s1_q[i]);
            end
            mode_s2_q <= mode_eff;
        end
    end

    // Stage 3: sums with rounding and chroma offset; stage 4: saturate.
    acc_t y_acc_q, cb_acc_q, cr_acc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_acc_q   <= '0;
            cb_acc_q  <= '0;
            cr_acc_q  <= '0;
            mode_s3_q <= MODE_RST;
            y_o       <= '0;
            cb_o      <= '0;
            cr_o      <= '0;
            mode_o    <= MODE_RST;
        end else begin
            y_acc_q   <= prod_y_q[0] + prod_y_q[1] + prod_y_q[2] + RND;
            cb_acc_q  <= prod_cb_q[0] + prod_cb_q[1] + prod_cb_q[2] + RND + MID;
            cr_acc_q  <= prod_cr_q[0] + prod_cr_q[1] + prod_cr_q[2] + RND + MID;
            mode_s3_q <= mode_s2_q;
            y_o       <= sat(y_acc_q);
            cb_o      <= sat(cb_acc_q);
            cr_o      <= sat(cr_acc_q);
            mode_o    <= mode_s3_q;
        end
    end

    logic [2:0] sync_out;

    sync_delay #(
        .WIDTH(3),
        .DEPTH(RGB2YCC_LAT)
    ) u_sync_delay (
        .clk(clk),
        .rst(rst),
        .d_i({dv_i, hs_i, vs_i}),
        .q_o(sync_out)
    );

    assign {dv_o, hs_o, vs_o} = sync_out;

    // Output-side position tracking; x_q holds the index the next valid pixel will take.
    logic          dv_prev_q, vs_prev_q, armed_q;
    logic [XW-1:0] x_q, x_now;
    logic [YW-1:0] line_q, line_now;
    logic          vs_rise, dv_fall, armed_now;

    always_comb begin
        vs_rise   = vs_o & ~vs_prev_q;
        dv_fall   = dv_prev_q & ~dv_o;
        x_now     = x_q;
        line_now  = line_q;
        armed_now = armed_q;
        if (vs_rise) begin
            x_now     = '0;
            line_now  = '0;
            armed_now = 1'b1;
        end else if (dv_fall) begin
            x_now = '0;
            if (line_q != Y_LAST) line_now = line_q + 1'b1;
        end
    end

    assign x_o           = x_now;
    assign line_o        = line_now;
    assign line_end_o    = dv_fall;
    assign frame_start_o = armed_now & dv_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dv_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
            armed_q   <= 1'b0;
            x_q       <= '0;
            line_q    <= '0;
        end else begin
            dv_prev_q <= dv_o;
            vs_prev_q <= vs_o;
            armed_q   <= armed_now & ~dv_o;
            x_q       <= (dv_o && x_now != X_LAST) ? x_now + 1'b1 : x_now;
            line_q    <= line_now;
        end
    end

endmodule

// File: tb/tb_rgb2ycbcr_pipe.sv
// Self-checking bench: directed colour points, mode switching, frame geometry, async reset,
// and randomized frames against a plain-arithmetic reference model.
module tb_rgb2ycbcr_pipe;

    localparam int MAX_W = 2048;
    localparam int MAX_H = 2048;
    localparam int LAT   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  red_i, green_i, blue_i;
    logic        dv_i, hs_i, vs_i;
    logic [1:0]  mode_i;
    logic [7:0]  y_o, cb_o, cr_o;
    logic        dv_o, hs_o, vs_o, line_end_o, frame_start_o;
    logic [10:0] x_o, line_o;
    logic [1:0]  mode_o;

    always #5 clk = ~clk;

    rgb2ycbcr_pipe #(
        .COLORDEPTH(8),
        .COEF_FRAC(10),
        .MAX_W(MAX_W),
        .MAX_H(MAX_H),
        .MODE_RST(2'd0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .red_i(red_i),
        .green_i(green_i),
        .blue_i(blue_i),
        .dv_i(dv_i),
        .hs_i(hs_i),
        .vs_i(vs_i),
        .mode_i(mode_i),
        .y_o(y_o),
        .cb_o(cb_o),
        .cr_o(cr_o),
        .dv_o(dv_o),
        .hs_o(hs_o),
        .vs_o(vs_o),
        .line_end_o(line_end_o),
        .frame_start_o(frame_start_o),
        .x_o(x_o),
        .line_o(line_o),
        .mode_o(mode_o)
    );

    typedef struct {
        int y, cb, cr;
        bit dv, hs, vs;
        int mode;
        bit lit;
        int ly, lcb, lcr, lm;
    } exp_t;

    // Rows: BT.601, BT.709, grey; columns: Y(r,g,b), Cb(r,g,b), Cr(r,g,b) in 1/1024 units.
    int coef_tab [3][9] = '{
        '{306, 601, 117, -173, -339, 512, 512, -429, -83},
        '{218, 732, 74, -117, -395, 512, 512, -465, -47},
        '{341, 342, 341, 0, 0, 0, 0, 0, 0}
    };

    exp_t pipe_q [$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   act_mode;
    bit   vs_in_prev;
    bit   o_dv_prev, o_vs_prev, o_armed;
    int   o_x, o_line;
    int   le_seen, fs_seen;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Divide by 1024 rounding down, then clip to the 8-bit range.
    function automatic int to_pix(input int acc);
        int v;
        v = acc >>> 10;
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    function automatic exp_t model_px(input int r, input int g, input int b, input int mode);
        exp_t e;
        int   s;
        e = '{default: 0};
        s = (mode == 1) ? 1 : (mode == 2) ? 2 : 0;
        e.y  = to_pix(coef_tab[s][0] * r + coef_tab[s][1] * g + coef_tab[s][2] * b + 512);
        e.cb = to_pix(coef_tab[s][3] * r + coef_tab[s][4] * g + coef_tab[s][5] * b + 512
                      + 128 * 1024);
        e.cr = to_pix(coef_tab[s][6] * r + coef_tab[s][7] * g + coef_tab[s][8] * b + 512
                      + 128 * 1024);
        e.mode = mode;
        return e;
    endfunction

    // After reset the output register is zero and the two inner stages hold black pixels.
    task automatic model_reset();
        exp_t z;
        z = '{default: 0};
        pipe_q.delete();
        pipe_q.push_back(z);
        for (int i = 0; i < LAT - 2; i++) pipe_q.push_back(model_px(0, 0, 0, 0));
        act_mode   = 0;
        vs_in_prev = 1'b0;
        o_dv_prev  = 1'b0;
        o_vs_prev  = 1'b0;
        o_armed    = 1'b0;
        o_x        = 0;
        o_line     = 0;
    endtask

    task automatic check_out(input exp_t e);
        check_eq("y", y_o, e.y);
        check_eq("cb", cb_o, e.cb);
        check_eq("cr", cr_o, e.cr);
        check_eq("dv", dv_o, e.dv);
        check_eq("hs", hs_o, e.hs);
        check_eq("vs", vs_o, e.vs);
        check_eq("mode", mode_o, e.mode);
        if (e.lit) begin
            check_eq("y_point", y_o, e.ly);
            check_eq("cb_point", cb_o, e.lcb);
            check_eq("cr_point", cr_o, e.lcr);
            check_eq("mode_point", mode_o, e.lm);
        end
        if (e.vs && !o_vs_prev) begin
            o_line  = 0;
            o_x     = 0;
            o_armed = 1'b1;
        end else if (o_dv_prev && !e.dv) begin
            o_x = 0;
            if (o_line < MAX_H - 1) o_line++;
        end
        check_eq("line_end", line_end_o, int'(o_dv_prev && !e.dv));
        check_eq("frame_start", frame_start_o, int'(o_armed && e.dv));
        if (e.dv) begin
            check_eq("x", x_o, o_x);
            check_eq("line", line_o, o_line);
            if (o_x < MAX_W - 1) o_x++;
            o_armed = 1'b0;
        end
        o_dv_prev = e.dv;
        o_vs_prev = e.vs;
        if (line_end_o) le_seen++;
        if (frame_start_o) fs_seen++;
    endtask

    task automatic drive(input bit dv, input bit hs, input bit vs, input int r, input int g,
                         input int b, input int mode, input bit lit = 1'b0, input int ly = 0,
                         input int lcb = 0, input int lcr = 0, input int lm = 0);
        exp_t e;
        red_i   = 8'(r);
        green_i = 8'(g);
        blue_i  = 8'(b);
        dv_i    = dv;
        hs_i    = hs;
        vs_i    = vs;
        mode_i  = 2'(mode);
        if (vs && !vs_in_prev) act_mode = mode;
        vs_in_prev = vs;
        e     = model_px(r, g, b, act_mode);
        e.dv  = dv;
        e.hs  = hs;
        e.vs  = vs;
        e.lit = lit;
        e.ly  = ly;
        e.lcb = lcb;
        e.lcr = lcr;
        e.lm  = lm;
        pipe_q.push_back(e);
        @(posedge clk);
        #1;
        check_out(pipe_q.pop_front());
    endtask

    function automatic int rnd8();
        return int'($urandom_range(255, 0));
    endfunction

    task automatic blank(input int n, input bit vs = 1'b0, input int mode = 0);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, vs, rnd8(), rnd8(), rnd8(), mode);
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_y"}, y_o, 0);
        check_eq({tag, "_cb"}, cb_o, 0);
        check_eq({tag, "_cr"}, cr_o, 0);
        check_eq({tag, "_sync"}, {dv_o, hs_o, vs_o}, 0);
        check_eq({tag, "_line_end"}, line_end_o, 0);
        check_eq({tag, "_frame_start"}, frame_start_o, 0);
        check_eq({tag, "_x"}, x_o, 0);
        check_eq({tag, "_line"}, line_o, 0);
        check_eq({tag, "_mode"}, mode_o, 0);
    endtask

    task automatic idle_inputs();
        {red_i, green_i, blue_i} = '0;
        {dv_i, hs_i, vs_i}       = '0;
        mode_i                   = 2'd0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        #2;
        check_reset("por");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // 3 x 5 frame with the BT.601 reference colours on the first line.
        le_seen = 0;
        fs_seen = 0;
        blank(2, 1'b1, 0);
        for (int l = 0; l < 3; l++) begin
            for (int p = 0; p < 5; p++) begin
                if (l == 0 && p == 0)      drive(1, 0, 0, 255, 255, 255, 0, 1, 255, 128, 128, 0);
                else if (l == 0 && p == 1) drive(1, 0, 0, 255, 0, 0, 0, 1, 76, 85, 255, 0);
                else if (l == 0 && p == 2) drive(1, 0, 0, 0, 0, 255, 0, 1, 29, 255, 107, 0);
                else                       drive(1, 0, 0, rnd8(), rnd8(), rnd8(), 0);
            end
            drive(0, 1, 0, rnd8(), rnd8(), rnd8(), 0);
            blank(2);
        end
        blank(LAT + 2);
        check_eq("frame_line_ends", le_seen, 3);
        check_eq("frame_starts", fs_seen, 1);

        // BT.709 requested mid-frame takes effect only at the next vsync rise.
        blank(1, 1'b1, 0);
        drive(1, 0, 0, 255, 255, 255, 0);
        drive(1, 0, 0, 0, 255, 0, 1, 1, 150, 44, 21, 0);
        drive(1, 0, 0, 0, 255, 0, 1, 1, 150, 44, 21, 0);
        blank(3, 1'b0, 2);
        drive(0, 0, 1, rnd8(), rnd8(), rnd8(), 1);
        drive(1, 0, 0, 0, 255, 0, 1, 1, 182, 30, 12, 1);
        drive(1, 0, 0, 0, 255, 0, 3, 1, 182, 30, 12, 1);
        blank(LAT + 1);

        // Randomized frames; a zero-length final blank overlaps the vsync rise with dv fall.
        for (int f = 0; f < 25; f++) begin
            int nl, nv, np, nb;
            nl = int'($urandom_range(4, 1));
            nv = int'($urandom_range(3, 1));
            for (int i = 0; i < nv; i++)
                drive(0, 0, 1, rnd8(), rnd8(), rnd8(), int'($urandom_range(3, 0)));
            for (int l = 0; l < nl; l++) begin
                np = int'($urandom_range(9, 1));
                for (int p = 0; p < np; p++)
                    drive(1, 0, 0, rnd8(), rnd8(), rnd8(), int'($urandom_range(3, 0)));
                nb = int'($urandom_range(3, (l == nl - 1) ? 0 : 1));
                for (int i = 0; i < nb; i++)
                    drive(0, 1, 0, rnd8(), rnd8(), rnd8(), int'($urandom_range(3, 0)));
            end
        end
        blank(LAT + 1);

        // Async reset in the middle of an active line.
        blank(1, 1'b1, 1);
        for (int p = 0; p < 6; p++) drive(1, 0, 0, 255, 255, 255, 1);
        #3;
        rst = 1'b1;
        #1;
        check_reset("mid");
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        le_seen = 0;
        fs_seen = 0;
        blank(LAT + 1);
        check_eq("post_reset_line_ends", le_seen, 0);
        check_eq("post_reset_frame_starts", fs_seen, 0);
        blank(1, 1'b1, 2);
        for (int l = 0; l < 2; l++) begin
            for (int p = 0; p < 4; p++) drive(1, 0, 0, rnd8(), rnd8(), rnd8(), 0);
            blank(2);
        end
        blank(LAT + 1);
        check_eq("post_reset_frame_line_ends", le_seen, 2);
        check_eq("post_reset_frame_frame_starts", fs_seen, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rgb2ycbcr_pipe.md
# rgb2ycbcr_pipe

Parametrised, fully pipelined RGB to Y/Cb/Cr converter for the HDMI video path. It sits between the HDMI RX pixel stream and the downstream luma and chroma processing blocks. It supersedes the fixed-coefficient luma-only converters. It adds selectable colour standard, switched only on frame boundaries, plus rounding and saturation, chroma outputs, and pixel/line position counters.

## Interface
- Clock `clk`; reset `rst` is asynchronous and active-high.
- `COLORDEPTH`, 8: bits per colour component, in and out (6..12).
- `COEF_FRAC`, 10: fractional bits of the fixed-point coefficients.
- `MAX_W`, 2048: maximum pixels per line; sets `x_o` width XW = $clog2(MAX_W).
- `MAX_H`, 2048: maximum lines per frame; sets `line_o` width YW = $clog2(MAX_H).
- `MODE_RST`, 2'd0: active mode after reset.
- `clk` in 1: pixel clock.
- `rst` in 1: async active-high reset.
- `red_i`, `green_i`, `blue_i` in COLORDEPTH: unsigned pixel components.
- `dv_i`, `hs_i`, `vs_i` in 1: data valid, hsync, vsync.
- `mode_i` in 2: requested standard. 0 = BT.601, 1 = BT.709, 2 = grey average, 3 = BT.601.
- `y_o`, `cb_o`, `cr_o` out COLORDEPTH: full-range results.
- `dv_o`, `hs_o`, `vs_o` out 1: sync signals delayed to align with the data.
- `line_end_o` out 1: one-cycle pulse at the end of each active line.
- `frame_start_o` out 1: one-cycle pulse coincident with the first `dv_o` of a frame.
- `x_o` out XW: pixel index of the current `dv_o` pixel.
- `line_o` out YW: line index of the current `dv_o` pixel.
- `mode_o` out 2: mode applied to the pixels currently at the output.

## Operation
- Coefficients are signed values scaled by 2^COEF_FRAC. The values below are for COEF_FRAC = 10; other COEF_FRAC values are rescaled and rounded.
- BT.601 coefficients:
  - Y: 306, 601, 117
  - Cb: -173, -339, 512
  - Cr: 512, -429, -83
- BT.709 coefficients:
  - Y: 218, 732, 74
  - Cb: -117, -395, 512
  - Cr: 512, -465, -47
- Grey coefficients: Y uses 341, 342, 341. Cb and Cr use all-zero coefficients, so the output is mid-scale.
- Y accumulator = sum of coefficient × component + 2^(COEF_FRAC-1).
- Cb and Cr accumulators add a further 2^(COLORDEPTH-1) << COEF_FRAC.
- Each result is the accumulator arithmetically shifted right by COEF_FRAC, then saturated to [0, 2^COLORDEPTH-1].
- Accumulator width is COLORDEPTH + COEF_FRAC + 3 bits, signed, with no internal overflow.
- Mode latch behaviour:
  - `mode_i` is sampled every cycle into a pending register.
  - The active mode is loaded from pending only on a rising edge of `vs_i` (`vs_i`=1 while the previous `vs_i`=0).
  - A mode change therefore never splits a frame.
  - The active mode travels down the pipeline with the data, and `mode_o` is its last stage.
- Position counters operate on the output side:
  - On a rising edge of `vs_o`: `line_o` is set to 0, `x_o` to 0, and frame-start is armed.
  - For each `dv_o`=1 cycle, `x_o` shows the current index; it increments afterwards and saturates at MAX_W-1.
  - On a falling edge of `dv_o`, `x_o` is set to 0 and `line_o` increments, saturating at MAX_H-1.
- `line_end_o` is high in the first cycle with `dv_o`=0 after a cycle with `dv_o`=1.
- `frame_start_o` is high on the first `dv_o`=1 after arming, then disarms.
- Simultaneous `vs_o` rise and `dv_o` fall: the `vs_o` reset wins for `line_o`. `line_end_o` still pulses.

## Timing
- Latency is 4 cycles from input to output: input register, products, sums with round, saturate into the output register.
- `dv_o`, `hs_o` and `vs_o` equal `dv_i`, `hs_i` and `vs_i` delayed by exactly 4 cycles.
- Throughput is one pixel per cycle. There is no backpressure.
- Reset values:
  - All outputs, pipeline registers and counters are 0.
  - Active and pending mode are MODE_RST, so `mode_o`=MODE_RST.
  - The frame-start flag is disarmed.
- Reset asserted mid-line clears everything immediately. The first frame after reset has no `frame_start_o` until a `vs_o` rising edge is seen.
- A mode request made in the same cycle as a `vs_i` rising edge is applied to that frame.

## Structure
- Package `video_pkg` holds:
  - the `mode_e` enum (MODE_601, MODE_709, MODE_GREY);
  - the `coef_set_t` struct (nine signed coefficients);
  - the function `get_coefs(mode_e)`;
  - the pipeline-latency constant `RGB2YCC_LAT` = 4.
- One sub-module, `sync_delay`, a parametrised N-stage shift register with async reset. It is instantiated for {dv, hs, vs}.

## Test plan
- Mode 0, RGB (255,255,255) → Y=255, Cb=128, Cr=128, 4 cycles after `dv_i`.
- Mode 0, RGB (255,0,0) → Y=76, Cb=85, Cr=255 (saturated from 256).
- Mode 0, RGB (0,0,255) → Y=29, Cb=255 (saturated), Cr=107.
- Mode change:
  - Mode 1 requested mid-frame → output stays BT.601 until the next `vs_i` rise.
  - After that, RGB (0,255,0) → Y=182, Cb=30, Cr=12, with `mode_o`=1.
- Frame of 3 lines × 5 pixels:
  - `x_o` runs 0..4 on each line, and `line_o` runs 0..2.
  - `line_end_o` gives 3 pulses, and `frame_start_o` gives one pulse on pixel (0,0).
- Async `rst` pulse mid-line → all outputs 0 within the same cycle. After release, the `dv_o` delay is exactly 4 and no spurious `line_end_o` occurs.
